// File: rtl/mouse_pos_ctl.sv
// Clamps mouse coordinates to the cursor-safe area and transfers them at vertical blank start.
// Define MOUSE_POS_FILTER_EN to average each new position with the previous output.
module mouse_pos_ctl #(
   parameter int H_RES = 800,
   parameter int V_RES = 600,
   parameter int CUR_W = 16,
   parameter int CUR_H = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblnk,
   input  logic        mouse_valid,
   input  logic [11:0] xpos_in,
   input  logic [11:0] ypos_in,
   input  logic        left_in,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        pos_changed,
   output logic        left_click
);

   localparam logic [11:0] X_MAX = 12'(H_RES - CUR_W);
   localparam logic [11:0] Y_MAX = 12'(V_RES - CUR_H);

   typedef enum logic [1:0] {IDLE, PEND, UPDATE} state_t;

   state_t      state, state_next;
   logic [11:0] shadow_x, shadow_y;
   logic [11:0] new_x, new_y;
   logic        left_seen, left_d, vblnk_d;
   logic        vblnk_rise, left_rise;

   assign vblnk_rise = vblnk & ~vblnk_d;
   assign left_rise  = mouse_valid & left_in & ~left_d;

   // A fresh sample takes priority in IDLE; a click-only frame still needs an UPDATE
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (mouse_valid)
               state_next = PEND;
            else if (vblnk_rise && left_seen)
               state_next = UPDATE;
         end
         PEND: begin
            if (vblnk_rise)
               state_next = UPDATE;
         end
         UPDATE: state_next = mouse_valid ? PEND : IDLE;
         default: state_next = IDLE;
      endcase
   end

`ifdef MOUSE_POS_FILTER_EN
   logic [12:0] sum_x, sum_y;

   always_comb begin
      sum_x = {1'b0, xpos} + {1'b0, shadow_x} + 13'd1;
      sum_y = {1'b0, ypos} + {1'b0, shadow_y} + 13'd1;
      new_x = sum_x[12:1];
      new_y = sum_y[12:1];
   end
`else
   always_comb begin
      new_x = shadow_x;
      new_y = shadow_y;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         xpos        <= '0;
         ypos        <= '0;
         pos_changed <= 1'b0;
         left_click  <= 1'b0;
         shadow_x    <= '0;
         shadow_y    <= '0;
         left_seen   <= 1'b0;
         left_d      <= 1'b0;
         vblnk_d     <= 1'b0;
      end else begin
         state       <= state_next;
         vblnk_d     <= vblnk;
         pos_changed <= 1'b0;
         left_click  <= 1'b0;
         if (mouse_valid) begin
            shadow_x <= (xpos_in > X_MAX) ? X_MAX : xpos_in;
            shadow_y <= (ypos_in > Y_MAX) ? Y_MAX : ypos_in;
            left_d   <= left_in;
         end
         // The shadow read here is the pre-edge value, so a sample arriving in UPDATE waits a frame
         if (state == UPDATE) begin
            xpos        <= new_x;
            ypos        <= new_y;
            pos_changed <= (new_x != xpos) || (new_y != ypos);
            left_click  <= left_seen | left_rise;
            left_seen   <= 1'b0;
         end else if (left_rise) begin
            left_seen <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mouse_pos_ctl.sv
// Directed and randomized bench for mouse_pos_ctl, checked against a frame-level reference model.
module tb_mouse_pos_ctl;

   localparam logic [11:0] X_LIM = 12'd784;
   localparam logic [11:0] Y_LIM = 12'd584;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        vblnk = 1'b0;
   logic        mouse_valid = 1'b0;
   logic [11:0] xpos_in = '0;
   logic [11:0] ypos_in = '0;
   logic        left_in = 1'b0;
   logic [11:0] xpos, ypos;
   logic        pos_changed, left_click;

   int total = 0;
   int bad = 0;

   // Reference model: latest clamped sample, whether it still awaits a frame,
   // a latched click, and whether an update lands on the next edge.
   logic [11:0] m_sx = '0, m_sy = '0;
   logic        m_left_prev = 1'b0, m_pending = 1'b0, m_click = 1'b0;
   logic        m_sched = 1'b0, m_vprev = 1'b0;
   logic [11:0] exp_x = '0, exp_y = '0;
   logic        exp_pc = 1'b0, exp_lc = 1'b0;

   mouse_pos_ctl dut (
      .clk(clk), .rst(rst), .vblnk(vblnk), .mouse_valid(mouse_valid),
      .xpos_in(xpos_in), .ypos_in(ypos_in), .left_in(left_in),
      .xpos(xpos), .ypos(ypos), .pos_changed(pos_changed), .left_click(left_click)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] clampv(input logic [11:0] v, input logic [11:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   function automatic logic [11:0] blend(input logic [11:0] old_v, input logic [11:0] new_v);
`ifdef MOUSE_POS_FILTER_EN
      int s;
      s = int'(old_v) + int'(new_v) + 1;
      return 12'(s / 2);
`else
      return new_v;
`endif
   endfunction

   task automatic model_edge();
      logic rise_v, brise;
      logic [11:0] nx, ny;
      if (!rst) begin
         m_sx = '0; m_sy = '0; m_left_prev = 0; m_pending = 0; m_click = 0;
         m_sched = 0; m_vprev = 0; exp_x = '0; exp_y = '0; exp_pc = 0; exp_lc = 0;
         return;
      end
      rise_v = vblnk && !m_vprev;
      brise  = mouse_valid && left_in && !m_left_prev;
      exp_pc = 0;
      exp_lc = 0;
      if (m_sched) begin
         nx = blend(exp_x, m_sx);
         ny = blend(exp_y, m_sy);
         exp_pc = (nx != exp_x) || (ny != exp_y);
         exp_x = nx;
         exp_y = ny;
         exp_lc = m_click || brise;
         m_click = 0;
         m_sched = 0;
         m_pending = mouse_valid;
      end else begin
         if (rise_v && (m_pending || (m_click && !mouse_valid))) begin
            m_sched = 1;
            m_pending = 0;
         end else begin
            m_pending = m_pending || mouse_valid;
         end
         if (brise) m_click = 1;
      end
      if (mouse_valid) begin
         m_sx = clampv(xpos_in, X_LIM);
         m_sy = clampv(ypos_in, Y_LIM);
         m_left_prev = left_in;
      end
      m_vprev = vblnk;
   endtask

   task automatic check_output();
      total += 4;
      assert (xpos === exp_x) else begin
         bad++; $error("[TB] FAIL xpos got=%0d exp=%0d t=%0t", xpos, exp_x, $time);
      end
      assert (ypos === exp_y) else begin
         bad++; $error("[TB] FAIL ypos got=%0d exp=%0d t=%0t", ypos, exp_y, $time);
      end
      assert (pos_changed === exp_pc) else begin
         bad++; $error("[TB] FAIL pos_changed got=%b exp=%b t=%0t", pos_changed, exp_pc, $time);
      end
      assert (left_click === exp_lc) else begin
         bad++; $error("[TB] FAIL left_click got=%b exp=%b t=%0t", left_click, exp_lc, $time);
      end
   endtask

   task automatic apply_stimulus(input logic r, input logic v, input logic [11:0] x,
                                 input logic [11:0] y, input logic l, input logic vb);
      rst = r; mouse_valid = v; xpos_in = x; ypos_in = y; left_in = l; vblnk = vb;
      @(posedge clk);
      model_edge();
      #1;
      check_output();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1, 0, '0, '0, left_in, 0);
   endtask

   task automatic sample(input logic [11:0] x, input logic [11:0] y, input logic l);
      apply_stimulus(1, 1, x, y, l, 0);
   endtask

   task automatic vblank(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1, 0, '0, '0, left_in, 1);
      idle(3);
   endtask

   initial begin
      $display("[TB] start");
      for (int i = 0; i < 3; i++) apply_stimulus(0, 0, '0, '0, 0, 0);
      idle(8); vblank(4); idle(8); vblank(4);

      idle(3); sample(12'd100, 12'd200, 0); idle(5); vblank(5);

      sample(12'd4095, 12'd590, 0); idle(4); vblank(4);
      sample(12'd784, 12'd584, 0); idle(4); vblank(4);

      sample(12'd10, 12'd10, 0); idle(2); sample(12'd20, 12'd30, 0); idle(3); vblank(4);

      sample(12'd50, 12'd60, 0); idle(2);
      apply_stimulus(1, 1, 12'd70, 12'd80, 0, 1);
      apply_stimulus(1, 1, 12'd90, 12'd95, 0, 1);
      apply_stimulus(1, 0, '0, '0, 0, 1);
      idle(6); vblank(4);

      sample(12'd90, 12'd95, 1); idle(4); vblank(4);
      sample(12'd90, 12'd95, 0); idle(4); vblank(4);

      sample(12'd300, 12'd300, 0); idle(2);
      apply_stimulus(0, 0, '0, '0, 0, 0);
      idle(3); vblank(4);

      for (int f = 0; f < 15; f++) begin
         for (int c = 0; c < 30; c++) begin
            logic        v;
            logic [11:0] rx, ry;
            v  = ($urandom_range(0, 4) == 0);
            rx = ($urandom_range(0, 3) == 0) ? 12'(783 + $urandom_range(0, 2)) : 12'($urandom_range(0, 4095));
            ry = ($urandom_range(0, 3) == 0) ? 12'(583 + $urandom_range(0, 2)) : 12'($urandom_range(0, 4095));
            apply_stimulus(1, v, rx, ry, v ? 1'($urandom_range(0, 1)) : left_in, c >= 24);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
